// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
//
// Shared definitions for the single-port RAM request controller:
//   - default RAM geometry (64-bit words, 12-bit word address)
//   - controller state encoding
//   - RAM control-pin bundle and the pin pattern each state presents
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 64;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      RD_ISSUE = 3'd2,
      RD_WAIT  = 3'd3,
      RESP     = 3'd4
   } ctrl_state_e;

   // RAM control pins, grouped so one registered assignment moves them together.
   typedef struct packed {
      logic cs;
      logic we;
      logic oe;
   } ram_pins_t;

   localparam ram_pins_t PINS_IDLE  = '{cs: 1'b0, we: 1'b0, oe: 1'b0};
   localparam ram_pins_t PINS_WRITE = '{cs: 1'b1, we: 1'b1, oe: 1'b0};
   localparam ram_pins_t PINS_READ  = '{cs: 1'b1, we: 1'b0, oe: 1'b1};

   // Pin pattern presented to the RAM while the controller sits in state s.
   // we and oe are never set together, so the bus can never see two drivers.
   function automatic ram_pins_t pins_for_state(input ctrl_state_e s);
      ram_pins_t p;
      p = PINS_IDLE;
      unique case (s)
         WRITE:            p = PINS_WRITE;
         RD_ISSUE,
         RD_WAIT:          p = PINS_READ;
         default:          p = PINS_IDLE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/ram_sp_ctrl.sv
// ---------------------------------------------------------------------------
// ram_sp_ctrl
//
// Request-side controller for a single-port, synchronous-read/synchronous-
// write RAM. Turns a valid/ready request stream into registered RAM pin
// activity, owns the shared tri-state data bus, and returns read data on a
// valid/ready response channel. One read is outstanding at a time; writes
// stream back-to-back at one per cycle and produce no response.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : request accepted on this edge when req_valid is also 1
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : read data available (held until rsp_ready)
//   rsp_ready  : consumer accepts the response
//   rsp_rdata  : read data
//   ram_cs     : RAM chip select (registered)
//   ram_we     : RAM write enable (registered, also the bus drive enable)
//   ram_oe     : RAM output enable (registered)
//   ram_addr   : RAM word address (registered)
//   ram_data   : shared bidirectional data bus
//
// Read timing (request accepted at edge N):
//   N..N+1  RD_ISSUE : RAM registers mem[addr] at N+1
//   N+1..N+2 RD_WAIT : RAM drives the bus, sampled into rsp_rdata at N+2
//   N+2..   RESP     : rsp_valid held until rsp_ready
// ---------------------------------------------------------------------------
module ram_sp_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,

   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   ctrl_state_e           state;
   ctrl_state_e           next_state;
   ram_pins_t             pins_d;
   logic                  accept;
   logic [DATA_WIDTH-1:0] wdata_q;

   // ------------------------------------------------------------------------
   // State register and registered RAM pins.
   // Pins are loaded from the pattern of the state being entered, so they
   // change on the same edge as the state and never glitch.
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_oe    <= 1'b0;
         ram_addr  <= '0;
         rsp_rdata <= '0;
      end else begin
         state  <= next_state;
         ram_cs <= pins_d.cs;
         ram_we <= pins_d.we;
         ram_oe <= pins_d.oe;
         if (accept) begin
            ram_addr <= req_addr;
         end
         // The RAM presents mem[addr] on the bus throughout RD_WAIT.
         if (state == RD_WAIT) begin
            rsp_rdata <= ram_data;
         end
      end
   end

   // NOTE: the write-data register has no reset: it only reaches the bus
   // while ram_we=1, which reset already forces low.
   always_ff @(posedge clk) begin
      if (accept) begin
         wdata_q <= req_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic.
   // IDLE and WRITE behave identically: both accept a new request and both
   // fall back to IDLE when nothing is offered.
   // ------------------------------------------------------------------------
   // NOTE: every variable written in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, WRITE: begin
            if (accept) begin
               next_state = req_write ? WRITE : RD_ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         RD_ISSUE: next_state = RD_WAIT;
         RD_WAIT:  next_state = RESP;
         RESP: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default:  next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs.
   // req_ready is masked by rst so a request coinciding with reset is never
   // reported as accepted.
   // ------------------------------------------------------------------------
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      pins_d    = pins_for_state(next_state);
      if (!rst && (state == IDLE || state == WRITE)) begin
         req_ready = 1'b1;
      end
      if (state == RESP) begin
         rsp_valid = 1'b1;
      end
      accept = req_valid && req_ready;
   end

   // Bus is driven only during WRITE; ram_oe is 0 whenever ram_we is 1.
   assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_ctrl
//
// Bench for ram_sp_ctrl together with a behavioural single-port RAM
// (synchronous write, registered read output driven while cs && oe && !we).
// Expected read data comes from hand-written constants or from an
// associative-array memory model updated on every accepted write.
// ---------------------------------------------------------------------------
module tb_ram_sp_ctrl;
   import ram_ctrl_pkg::*;

   localparam int DW = 64;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_cs;
   logic          ram_we;
   logic          ram_oe;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_oe    (ram_oe),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data)
   );

   // ---------------- behavioural RAM ----------------
   logic [DW-1:0] ram_mem [0:(1<<AW)-1] = '{default: '0};
   logic [DW-1:0] ram_rd_q = '0;

   always @(posedge clk) begin
      if (ram_cs && ram_we)      ram_mem[ram_addr] <= ram_data;
      else if (ram_cs && ram_oe) ram_rd_q <= ram_mem[ram_addr];
   end
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : {DW{1'bz}};

   // ---------------- reference memory ----------------
   logic [DW-1:0] model_mem [int];

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Continuous bus-safety checks, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("we_oe_exclusive", 64'(ram_we & ram_oe), 64'd0);
         if (ram_cs) check("bus_known", 64'($isunknown(ram_data)), 64'd0);
      end
   end

   // One request, starting and ending at a negedge. Writes return right after
   // acceptance so a following request is offered back-to-back.
   task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp, input int stall, input string tag);
      int            cyc;
      logic [DW-1:0] held;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = (stall == 0);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (wr) begin
         check({tag, "_wr_pins"}, 64'({ram_cs, ram_we, ram_oe}), 64'(3'b110));
         check({tag, "_wr_addr"}, 64'(ram_addr), 64'(addr));
         model_mem[int'(addr)] = wdata;
      end else begin
         check({tag, "_rd_pins"}, 64'({ram_cs, ram_we, ram_oe}), 64'(3'b101));
         check({tag, "_rd_addr"}, 64'(ram_addr), 64'(addr));
         cyc = 1;
         while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
            check({tag, "_rd_no_drive"}, 64'(ram_we), 64'd0);
         end
         check({tag, "_latency"}, 64'(cyc - 1), 64'd2);
         check({tag, "_rdata"}, rsp_rdata, exp);
         check({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
         held = rsp_rdata;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, held);
            check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
         check({tag, "_ready_again"}, 64'(req_ready), 64'd1);
      end
   endtask

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
      int            stall;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            w;

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_pins", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
      check("rst_addr", 64'(ram_addr), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 64'(req_ready), 64'd1);

      // ---- back-to-back writes ----
      do_req(1'b1, 12'h000, 64'hA5, '0, 0, "w0");
      do_req(1'b1, 12'h018, 64'h1234, '0, 0, "w18");
      @(negedge clk);
      check("mem0", ram_mem[0], 64'hA5);
      check("mem24", ram_mem[24], 64'h1234);
      check("idle_pins", 64'({ram_cs, ram_we, ram_oe}), 64'd0);

      // ---- reads ----
      do_req(1'b0, 12'h018, '0, 64'h1234, 0, "r18");
      do_req(1'b1, 12'h101, 64'h123456789AB, '0, 0, "w101");
      do_req(1'b0, 12'h000, '0, 64'hA5, 0, "r0");
      do_req(1'b0, 12'h101, '0, 64'h123456789AB, 0, "r101");

      // ---- backpressure ----
      do_req(1'b0, 12'h000, '0, 64'hA5, 5, "r0_bp");

      // ---- reset during RD_WAIT, with a request offered under reset ----
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h000; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rdwait_oe", 64'({ram_cs, ram_oe}), 64'(2'b11));
      rst = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h3C; req_wdata = 64'hBAD;
      @(negedge clk);
      check("midrst_pins", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
      check("midrst_addr", 64'(ram_addr), 64'd0);
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_rsp_rdata", rsp_rdata, 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      check("rst_req_not_taken", 64'(ram_we), 64'd0);
      rst = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
      end
      check("mem3c_untouched", ram_mem[12'h3C], 64'd0);

      // ---- table-driven vectors ----
      vecs[0] = '{1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0};
      vecs[1] = '{1'b0, 12'hFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[2] = '{1'b1, 12'h001, 64'h0, 64'h0, 0};
      vecs[3] = '{1'b1, 12'h002, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0};
      vecs[4] = '{1'b0, 12'h001, 64'h0, 64'h0, 0};
      vecs[5] = '{1'b0, 12'h002, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 2};
      vecs[6] = '{1'b0, 12'h018, 64'h0, 64'h1234, 1};
      vecs[7] = '{1'b1, 12'h018, 64'h5555_AAAA_5555_AAAA, 64'h0, 0};
      vecs[8] = '{1'b0, 12'h018, 64'h0, 64'h5555_AAAA_5555_AAAA, 0};
      for (int i = 0; i < 9; i++) begin
         do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].stall,
                $sformatf("vec%0d", i));
      end

      // ---- randomized traffic against the reference memory ----
      for (int i = 0; i < 150; i++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
         d = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         do_req(w, a, d, model_read(a), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                $sformatf("rnd%0d", i));
      end
      req_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
